// File: rtl/processing_element.sv
`default_nettype none
// ============================================================================
// Module      : processing_element
// Description : Systolic-array MAC cell. Forwards A east and B south, keeps a
//               wrapping N-bit accumulator and drains it onto Bout on write.
// Revision    : 1.0 - initial release
// ============================================================================
module processing_element #(
    parameter int N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Aout,
    output logic [N-1:0] Bout,
    input  logic         clk,
    input  logic         clr,
    input  logic         read,
    input  logic         write
);

    logic [N-1:0] r_acc;
    logic [N-1:0] r_aout;
    logic [N-1:0] r_bout;

    logic [N-1:0] w_prod;
    logic [N-1:0] w_acc_next;

    // Product keeps only its low N bits; the accumulator wraps modulo 2^N.
    assign w_prod     = A * B;
    assign w_acc_next = read ? (r_acc + w_prod) : r_acc;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_acc  <= '0;
            r_aout <= '0;
            r_bout <= '0;
        end else begin
            r_acc <= w_acc_next;
            if (read) begin
                r_aout <= A;
            end
            // A drain takes priority over forwarding B and shows the
            // post-accumulate value when read and write coincide.
            if (write) begin
                r_bout <= w_acc_next;
            end else if (read) begin
                r_bout <= B;
            end
        end
    end

    assign Aout = r_aout;
    assign Bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_processing_element.sv
`default_nettype none
// ============================================================================
// Module      : tb_processing_element
// Description : Randomized and directed checks of processing_element against
//               an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_processing_element;

    localparam int N = 32;

    logic         clk;
    logic         clr;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] Aout;
    logic [N-1:0] Bout;
    logic         read;
    logic         write;

    int n_tests;
    int n_fail;

    // Reference state: accumulator and the two forwarded values.
    longint unsigned m_acc;
    longint unsigned m_a;
    longint unsigned m_b;

    processing_element #(.N(N)) dut (
        .A     (A),
        .B     (B),
        .Aout  (Aout),
        .Bout  (Bout),
        .clk   (clk),
        .clr   (clr),
        .read  (read),
        .write (write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0;
        m_a   = 0;
        m_b   = 0;
    endtask

    // One clocked cycle: apply inputs, update the model at the edge, then
    // compare both outputs shortly after the edge.
    task automatic cycle(input string tag, input logic r, input logic w,
                         input logic [N-1:0] a, input logic [N-1:0] b);
        longint unsigned mod;
        mod   = 64'd1 << N;
        A     = a;
        B     = b;
        read  = r;
        write = w;
        @(posedge clk);
        if (r) begin
            m_acc = (m_acc + ((longint'(a) * longint'(b)) % mod)) % mod;
            m_a   = a;
        end
        if (w)      m_b = m_acc;
        else if (r) m_b = b;
        #1;
        check({tag, "_aout"}, Aout, m_a[N-1:0]);
        check({tag, "_bout"}, Bout, m_b[N-1:0]);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        clr   = 1'b1;
        A     = 5;
        B     = 2;
        read  = 1'b0;
        write = 1'b0;

        // Held in reset with clocks running.
        repeat (3) @(posedge clk);
        #1;
        check("rst_aout", Aout, '0);
        check("rst_bout", Bout, '0);
        clr = 1'b0;

        // Single MAC with simultaneous drain, then hold.
        cycle("mac_drain", 1'b1, 1'b1, 20, 2);
        check("mac_drain_40", Bout, 32'd40);
        cycle("mac_hold", 1'b0, 1'b0, 7, 9);
        check("mac_hold_20", Aout, 32'd20);

        // Async clear mid-cycle, then accumulate-and-drain sequence.
        @(negedge clk);
        clr = 1'b1;
        #1;
        check("async_aout", Aout, '0);
        check("async_bout", Bout, '0);
        model_reset();
        @(posedge clk);
        #1;
        clr = 1'b0;
        cycle("acc1", 1'b1, 1'b0, 3, 4);
        cycle("acc2", 1'b1, 1'b0, 5, 6);
        cycle("acc3", 1'b1, 1'b0, 7, 8);
        check("acc3_b8", Bout, 32'd8);
        cycle("drain1", 1'b0, 1'b1, 0, 0);
        check("drain1_98", Bout, 32'd98);
        check("drain1_a7", Aout, 32'd7);
        cycle("drain2", 1'b0, 1'b1, 1, 1);
        check("drain2_98", Bout, 32'd98);

        // Idle with toggling operands.
        for (int i = 0; i < 10; i++) begin
            cycle("idle", 1'b0, 1'b0, $urandom, $urandom);
        end
        cycle("idle_acc", 1'b0, 1'b1, 0, 0);

        // Wrap-around and truncation.
        clr = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        clr = 1'b0;
        cycle("pre", 1'b1, 1'b0, 32'hFFFF_FFF0, 1);
        cycle("wrap", 1'b1, 1'b1, 32'h20, 1);
        check("wrap_10", Bout, 32'h10);
        cycle("trunc", 1'b1, 1'b1, 32'h0001_0000, 32'h0001_0000);
        check("trunc_10", Bout, 32'h10);

        // Reset after several MACs discards the partial sum.
        for (int i = 0; i < 4; i++) begin
            cycle("pre_rst", 1'b1, 1'b0, $urandom, $urandom);
        end
        @(negedge clk);
        clr = 1'b1;
        #2;
        clr = 1'b0;
        model_reset();
        cycle("restart", 1'b1, 1'b1, 1, 1);
        check("restart_1", Bout, 32'd1);

        // Randomized traffic, occasionally with small operands.
        for (int i = 0; i < 300; i++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            ra = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : N'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : N'($urandom);
            cycle("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/processing_element.md
# processing_element

Multiply-accumulate processing element for the systolic-array datapath, one instance per array cell. Each cell registers the incoming A (row) and B (column) operands and forwards them to its neighbours. It accumulates A×B into a local N-bit accumulator. On request it drives the accumulated result out on the B-side output so results can be drained down a column.

## Interface
- N, default 32: operand, accumulator and output width in bits.

- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  reset, asynchronous, active-high; clears all state.
- A  input  N  row operand from the west neighbour or array edge.
- B  input  N  column operand from the north neighbour or array edge.
- Aout  output  N  registered A forwarded to the east neighbour.
- Bout  output  N  registered B forwarded south, or the accumulator value during a write.
- read  input  1  operand strobe: consume A/B this cycle, forward them and accumulate.
- write  input  1  result strobe: drive the accumulator onto Bout.

Port order at instantiation: A, B, Aout, Bout, clk, clr, read, write.

## Operation
- State is three N-bit registers: acc, Aout, Bout. Outputs come straight from registers, with no combinational path from inputs to outputs.
- Product: P = A × B, unsigned, truncated to the low N bits. Accumulation wraps modulo 2^N; there is no overflow flag and no saturation.
- Next accumulator value: acc_next = acc + P when read=1, else acc_next = acc.
- On each rising clk edge with clr=0:
  - acc <= acc_next.
  - Aout <= A if read=1; otherwise Aout holds.
  - Bout <= acc_next if write=1. Otherwise Bout <= B if read=1. Otherwise Bout holds.
- Simultaneous read=1 and write=1:
  - The product is accumulated and Bout shows the post-accumulate value on the same edge.
  - Aout still forwards A.
  - B is not forwarded in that cycle.
- A write is non-destructive: acc keeps its value after a drain. Only clr zeroes acc.
- read=0 and write=0: all registers hold. This is the idle/stall state.
- Inputs are ignored while clr=1.

## Timing
- Reset: clr=1 forces acc, Aout and Bout to 0 immediately, without waiting for a clock edge. They stay 0 while clr=1.
- Reset release: the first rising edge after clr falls is the first functional edge.
- Reset mid-operation: any in-flight accumulation is discarded and no partial result survives.
- Latency: 1 cycle from A/B sampled (read=1) to Aout/Bout valid. Likewise 1 cycle from write=1 to the result on Bout.
- Throughput: one MAC per cycle with read held high.
- No handshake or back-pressure: read and write are single-cycle strobes sampled at each edge.
- Wrap-around example (N=32): acc=0xFFFFFFFF, A=1, B=1, read=1 → acc=0x00000000.
- Width: a product wider than N bits contributes only its low N bits. Example: A=B=0x00010000 gives P=0.

## Test plan
- Reset: clr=1 with A=5, B=2, read=0, write=0, clocks running → Aout=0, Bout=0, acc=0. Then assert clr asynchronously between clock edges → outputs go to 0 without waiting for an edge.
- Single MAC plus drain: after clr release, one cycle with read=1, write=1, A=20, B=2 → next edge gives Aout=20, Bout=40. With read=write=0 afterwards, both outputs hold 20 and 40.
- Accumulate then drain:
  - Three read-only cycles with (A,B) = (3,4), (5,6), (7,8) → Aout=7 and Bout=8 after the third edge.
  - Then a write-only cycle → Bout=98, Aout still 7.
  - A second write → Bout=98 again, showing the drain is non-destructive.
- Idle hold: read=write=0 for 10 cycles while A and B toggle randomly → Aout, Bout and acc unchanged.
- Wrap/truncation (N=32): preload acc=0xFFFFFFF0 via MAC, then read with A=0x20, B=1 and write=1 → Bout=0x00000010. Separately, A=B=0x00010000 accumulates 0.
- Reset mid-run: clr pulse after several MACs, then a single read+write with A=1, B=1 → Bout=1, confirming acc restarted from 0.
